// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 11;  // start + 8 data + parity + stop

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the UART transmit arbiter: per-requester byte
// handshake plus the serial line and status seen by the producers.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import uart_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx;
    logic                           busy;
    logic [$clog2(NUM_REQ)-1:0]     grant_id;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx, busy, grant_id
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping,
// and returns the first active request as one-hot grant plus its index.
module uart_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_idx;
    logic             found;

    // NOTE: every variable gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        grant    = '0;
        idx      = last;
        found    = 1'b0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// One UART serializer shared by NUM_REQ byte producers, round-robin arbitrated.
// Optional statistics outputs (frames_sent, arb_conflict) under UART_TX_ARB_STATS_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [15:0]        frames_sent,
    output logic               arb_conflict
`endif
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    uart_state_e            state, state_d;
    logic [BAUD_W-1:0]      baud_cnt;
    logic [2:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shreg, win_data;
    logic                   parity_q, tx_q, tx_d;
    logic [IDX_W-1:0]       grant_id_q, win_idx;
    logic [NUM_REQ-1:0]     win_grant;
    logic                   any_valid, bit_end, accept;

    uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req_valid),
        .last  (grant_id_q),
        .grant (win_grant),
        .idx   (win_idx)
    );

    assign any_valid = |bus.req_valid;
    assign bit_end   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_grant[i]) win_data = bus.req_data[i*UART_DATA_W +: UART_DATA_W];
        end
    end

    // NOTE: state is a flop, so it is updated with <= to avoid read/write
    // ordering races between clocked processes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // tx_d is the value tx takes after this edge; the line itself is a flop.
    always_comb begin
        state_d = state;
        tx_d    = tx_q;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (any_valid) begin
                    accept  = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                tx_d    = shreg[0];
            end
            DATA: if (bit_end) begin
                if (bit_cnt == 3'd7) begin
                    state_d = PARITY;
                    tx_d    = parity_q;
                end else begin
                    tx_d = shreg[1];
                end
            end
            PARITY: if (bit_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (bit_end) begin
                if (any_valid) begin
                    accept  = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q       <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_q   <= 1'b0;
            grant_id_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            tx_q <= tx_d;
            if (accept) begin
                baud_cnt   <= '0;
                bit_cnt    <= '0;
                shreg      <= win_data;
                parity_q   <= (PARITY_ODD != 0) ? ~^win_data : ^win_data;
                grant_id_q <= win_idx;
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                if (bit_end && state == DATA) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= shreg >> 1;
                end
            end
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = (state != IDLE);
    assign bus.req_ready = accept ? win_grant : '0;
    assign bus.grant_id  = grant_id_q;

`ifdef UART_TX_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_sent  <= '0;
            arb_conflict <= 1'b0;
        end else begin
            // More than one bit set: clearing the lowest set bit leaves a remainder.
            arb_conflict <= accept && ((bus.req_valid & (bus.req_valid - 1'b1)) != '0);
            if (state == STOP && bit_end) frames_sent <= frames_sent + 16'd1;
        end
    end
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit serializer between NUM_REQ byte requesters using round-robin arbitration.
- Accepts one byte per grant through a valid/ready handshake.
- Sequences the frame: start bit, 8 data bits LSB-first, parity bit, stop bit, each held for CLKS_PER_BIT clocks.
- Sits between the protocol producers and the serial pin, so no single producer can monopolise the line.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- CLKS_PER_BIT, 16: clock cycles per serial bit (>=2).
- PARITY_ODD, 0: 0 selects even parity (^data); 1 selects odd parity (~^data).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, single-cycle accept pulse.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.

Behaviour:
- Reset (asynchronous assert, synchronous deassert at clk):
  - state=IDLE, tx=1, busy=0, req_ready=0, grant_id=NUM_REQ-1, bit/baud counters=0.
  - Consequence: requester 0 has first priority after reset.
- States: IDLE, START, DATA, PARITY, STOP.
- Arbitration (combinational; takes effect in the accept cycle):
  - Search order is grant_id+1 .. NUM_REQ-1, then 0 .. grant_id.
  - The first requester with req_valid=1 wins.
- Accept cycle (IDLE with any valid, or last cycle of STOP with any valid):
  - req_ready[w]=1 for exactly that cycle; shift register <= req_data[w]; grant_id <= w.
  - Next state is START.
- Requester rules:
  - A requester must hold req_valid and req_data stable until it sees req_ready.
  - Dropping req_valid before the grant is legal; that requester is simply not considered.
- IDLE: tx=1, busy=0. Remains in IDLE while no req_valid.
- Frame timing:
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shreg[0]. Shift right at each bit boundary. bit_cnt 0..7; leave after bit 7.
  - PARITY: tx=parity of the latched byte, computed at accept and registered.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
- busy=1 from the cycle after accept through the final STOP cycle.
- Latency: the first START cycle on tx is 1 clock after req_ready.
- Frame length: exactly 11*CLKS_PER_BIT cycles.
- Back-to-back frames:
  - If any valid is present in the last STOP cycle, the next accept happens in that same cycle.
  - No idle gap; busy stays high.
  - Otherwise the block returns to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; the bit boundary is at CLKS_PER_BIT-1.
  - Cleared on accept.
- tx is driven from a flop, so it is glitch-free.
- Reset mid-frame: tx goes to 1 immediately (asynchronous), the frame is abandoned, and there is no req_ready pulse.
- A requester holding valid during a frame is not acknowledged until the next accept cycle.

Optional Feature:
- Macro: UART_TX_ARB_STATS_EN.
- When defined:
  - Adds output frames_sent, 16 bits, reset to 0.
  - Increments once in the last STOP cycle of each completed frame; wraps 0xFFFF -> 0.
  - Adds output arb_conflict, 1 bit: registered, high for one cycle after an accept cycle in which more than one req_valid was asserted.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - UART_DATA_W=8;
  - the frame-length constant UART_FRAME_BITS=11.
- Sub-module uart_rr_arbiter: NUM_REQ-wide round-robin picker.
  - Inputs: req, last pointer. Outputs: one-hot grant, index.
  - Combinational.
- The FSM, counters and shifter stay in uart_tx_arbiter.

Test Plan:
1. Reset, then req_valid[0]=1, data 0xA5, CLKS_PER_BIT=16:
   - req_ready[0] pulses once.
   - tx holds each of these values for 16 cycles: 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1.
   - busy falls after 176 cycles.
2. All four requesters valid continuously, data 0x11/0x22/0x33/0x44:
   - Grant order is 0,1,2,3,0.
   - Frames are back-to-back with no high gap between stop and start.
3. Requester 2 valid only (0x01), PARITY_ODD=1:
   - Parity bit is 0.
   - With PARITY_ODD=0 the parity bit is 1.
   - grant_id=2 afterwards.
4. Assert rst low mid-DATA of a 0xFF frame:
   - tx=1 asynchronously; busy=0.
   - After release, requester 0 wins against a simultaneous requester 3.
5. req_valid[1] pulsed high for 1 cycle during a busy frame, then dropped:
   - No req_ready[1].
   - The block returns to IDLE after the frame.
6. UART_TX_ARB_STATS_EN defined, 3 frames with two requesters simultaneously valid at the first accept:
   - frames_sent=3.
   - arb_conflict pulses once.
